// File: rtl/dispatch_router.sv
// -----------------------------------------------------------------------------
// dispatch_router
//
// Producer side of the reservation-station dispatch interface. Accepts a 2-wide
// in-order bundle of renamed instructions from rename, steers each one to the
// ALU, LSU or BRU reservation station by opcode, and drives that station's
// registered dispatch ports one cycle later. The stations have no backpressure,
// so a free-entry credit counter per station gates acceptance of a bundle.
// A bundle is placed whole or not at all.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   flush                    pipeline flush: drops the bundle, refills credits
//   in_instruction_0/1       bundle payload, slot 0 is the oldest
//   in_rob_id_0/1            ROB ids of the bundle slots
//   in_valid_0/1             slot valids (slot 1 only counts with slot 0)
//   in_ready                 bundle accepted this cycle when high with a valid
//   {alu,lsu,bru}_issue_valid                 credit return, one per cycle
//   {alu,lsu,bru}_dispatch_instruction_0/1    per-station dispatch payload
//   {alu,lsu,bru}_rob_id_0/1                  per-station ROB id
//   {alu,lsu,bru}_dispatch_valid_0/1          single-cycle dispatch strobes
//   {alu,lsu,bru}_credit                      current free-entry credits
//
// Optional build macro DISPATCH_STATS_EN adds saturating 32-bit per-station
// stall counters stall_{alu,lsu,bru}_cnt.
// -----------------------------------------------------------------------------
package dispatch_router_pkg;

    typedef struct packed {
        logic [24:0] fields;  // renamed operands/immediate, opaque to routing
        logic [6:0]  opcode;
    } instruction_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int RS_ALU = 0;
    localparam int RS_LSU = 1;
    localparam int RS_BRU = 2;
    localparam int NUM_RS = 3;

    // One-hot station select, bit index RS_ALU / RS_LSU / RS_BRU.
    function automatic logic [2:0] route(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_STORE:           route = 3'b010;
            OPC_BRANCH, OPC_JAL, OPC_JALR: route = 3'b100;
            default:                       route = 3'b001;
        endcase
    endfunction

endpackage

module dispatch_router
    import dispatch_router_pkg::*;
#(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int ROB_WIDTH      = 4,
    localparam int CW            = $clog2(NUM_RS_ENTRIES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  instruction_t         in_instruction_0,
    input  logic [ROB_WIDTH-1:0] in_rob_id_0,
    input  logic                 in_valid_0,
    input  instruction_t         in_instruction_1,
    input  logic [ROB_WIDTH-1:0] in_rob_id_1,
    input  logic                 in_valid_1,
    output logic                 in_ready,
    input  logic                 alu_issue_valid,
    input  logic                 lsu_issue_valid,
    input  logic                 bru_issue_valid,
    output instruction_t         alu_dispatch_instruction_0,
    output instruction_t         alu_dispatch_instruction_1,
    output logic [ROB_WIDTH-1:0] alu_rob_id_0,
    output logic [ROB_WIDTH-1:0] alu_rob_id_1,
    output logic                 alu_dispatch_valid_0,
    output logic                 alu_dispatch_valid_1,
    output instruction_t         lsu_dispatch_instruction_0,
    output instruction_t         lsu_dispatch_instruction_1,
    output logic [ROB_WIDTH-1:0] lsu_rob_id_0,
    output logic [ROB_WIDTH-1:0] lsu_rob_id_1,
    output logic                 lsu_dispatch_valid_0,
    output logic                 lsu_dispatch_valid_1,
    output instruction_t         bru_dispatch_instruction_0,
    output instruction_t         bru_dispatch_instruction_1,
    output logic [ROB_WIDTH-1:0] bru_rob_id_0,
    output logic [ROB_WIDTH-1:0] bru_rob_id_1,
    output logic                 bru_dispatch_valid_0,
    output logic                 bru_dispatch_valid_1,
    output logic [CW-1:0]        alu_credit,
    output logic [CW-1:0]        lsu_credit,
    output logic [CW-1:0]        bru_credit
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]          stall_alu_cnt,
    output logic [31:0]          stall_lsu_cnt,
    output logic [31:0]          stall_bru_cnt
`endif
);

    localparam logic [CW-1:0] CREDIT_FULL = CW'(NUM_RS_ENTRIES);
    localparam logic [CW:0]   CREDIT_MAX  = (CW+1)'(NUM_RS_ENTRIES);

    logic [CW-1:0]        credit_q [NUM_RS];
    logic [CW-1:0]        credit_d [NUM_RS];
    logic [CW:0]          credit_sum [NUM_RS];
    logic [1:0]           valid_q [NUM_RS];
    logic [1:0]           valid_d [NUM_RS];
    instruction_t         ins_q [NUM_RS][2];
    instruction_t         ins_d [NUM_RS][2];
    logic [ROB_WIDTH-1:0] rob_q [NUM_RS][2];
    logic [ROB_WIDTH-1:0] rob_d [NUM_RS][2];

    logic [2:0] hit0;        // slot 0 routed to station (and valid)
    logic [2:0] hit1;        // slot 1 routed to station (and part of bundle)
    logic [2:0] credit_ret;
    logic [1:0] demand [NUM_RS];
    logic [2:0] short;       // station cannot take its share of the bundle
    logic [2:0] overflow;
    logic       accept;

    // NOTE: every variable an always_comb writes gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        hit0       = in_valid_0 ? route(in_instruction_0.opcode) : 3'b000;
        hit1       = (in_valid_0 && in_valid_1) ? route(in_instruction_1.opcode) : 3'b000;
        credit_ret = {bru_issue_valid, lsu_issue_valid, alu_issue_valid};
        for (int s = 0; s < NUM_RS; s++) begin
            demand[s] = {1'b0, hit0[s]} + {1'b0, hit1[s]};
            short[s]  = {{(CW-1){1'b0}}, demand[s]} > {1'b0, credit_q[s]};
        end
        // Readiness looks at registered credits only; same-cycle returns wait.
        in_ready = ~|short;
        accept   = in_ready & in_valid_0 & ~flush;
    end

    always_comb begin
        for (int s = 0; s < NUM_RS; s++) begin
            credit_sum[s] = {1'b0, credit_q[s]}
                          - (accept ? {{(CW-1){1'b0}}, demand[s]} : {(CW+1){1'b0}})
                          + {{CW{1'b0}}, credit_ret[s]};
            overflow[s]   = ~flush & (credit_sum[s] > CREDIT_MAX);
            if (flush || overflow[s]) begin
                credit_d[s] = CREDIT_FULL;
            end else begin
                credit_d[s] = credit_sum[s][CW-1:0];
            end
        end
    end

    // Steering: the first instruction a station receives goes on port 0, a
    // second one (always the younger slot 1) on port 1. Unused ports hold.
    always_comb begin
        for (int s = 0; s < NUM_RS; s++) begin
            valid_d[s] = 2'b00;
            ins_d[s]   = ins_q[s];
            rob_d[s]   = rob_q[s];
            if (accept) begin
                if (hit0[s]) begin
                    ins_d[s][0]   = in_instruction_0;
                    rob_d[s][0]   = in_rob_id_0;
                    valid_d[s][0] = 1'b1;
                end
                if (hit1[s]) begin
                    if (hit0[s]) begin
                        ins_d[s][1]   = in_instruction_1;
                        rob_d[s][1]   = in_rob_id_1;
                        valid_d[s][1] = 1'b1;
                    end else begin
                        ins_d[s][0]   = in_instruction_1;
                        rob_d[s][0]   = in_rob_id_1;
                        valid_d[s][0] = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_RS; s++) begin
                credit_q[s] <= CREDIT_FULL;
                valid_q[s]  <= 2'b00;
                // NOTE: payload registers are reset too because the ports must
                // read zero out of reset; they are few, not a RAM.
                for (int p = 0; p < 2; p++) begin
                    ins_q[s][p] <= '0;
                    rob_q[s][p] <= '0;
                end
            end
        end else begin
            credit_q <= credit_d;
            valid_q  <= valid_d;
            ins_q    <= ins_d;
            rob_q    <= rob_d;
        end
    end

    // A station returning more entries than it holds is a protocol error.
    credit_never_overflows: assert property (@(posedge clk) disable iff (rst) overflow == 3'b000);

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cnt_q [NUM_RS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_RS; s++) stall_cnt_q[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_RS; s++) begin
                if (in_valid_0 && !flush && short[s] && stall_cnt_q[s] != 32'hFFFF_FFFF) begin
                    stall_cnt_q[s] <= stall_cnt_q[s] + 32'd1;
                end
            end
        end
    end

    assign stall_alu_cnt = stall_cnt_q[RS_ALU];
    assign stall_lsu_cnt = stall_cnt_q[RS_LSU];
    assign stall_bru_cnt = stall_cnt_q[RS_BRU];
`endif

    assign alu_dispatch_instruction_0 = ins_q[RS_ALU][0];
    assign alu_dispatch_instruction_1 = ins_q[RS_ALU][1];
    assign alu_rob_id_0               = rob_q[RS_ALU][0];
    assign alu_rob_id_1               = rob_q[RS_ALU][1];
    assign alu_dispatch_valid_0       = valid_q[RS_ALU][0];
    assign alu_dispatch_valid_1       = valid_q[RS_ALU][1];
    assign lsu_dispatch_instruction_0 = ins_q[RS_LSU][0];
    assign lsu_dispatch_instruction_1 = ins_q[RS_LSU][1];
    assign lsu_rob_id_0               = rob_q[RS_LSU][0];
    assign lsu_rob_id_1               = rob_q[RS_LSU][1];
    assign lsu_dispatch_valid_0       = valid_q[RS_LSU][0];
    assign lsu_dispatch_valid_1       = valid_q[RS_LSU][1];
    assign bru_dispatch_instruction_0 = ins_q[RS_BRU][0];
    assign bru_dispatch_instruction_1 = ins_q[RS_BRU][1];
    assign bru_rob_id_0               = rob_q[RS_BRU][0];
    assign bru_rob_id_1               = rob_q[RS_BRU][1];
    assign bru_dispatch_valid_0       = valid_q[RS_BRU][0];
    assign bru_dispatch_valid_1       = valid_q[RS_BRU][1];
    assign alu_credit                 = credit_q[RS_ALU];
    assign lsu_credit                 = credit_q[RS_LSU];
    assign bru_credit                 = credit_q[RS_BRU];

endmodule

// File: doc/dispatch_router.md
Name: dispatch_router

Overview:
- Producer side of the reservation-station dispatch interface.
- Takes a 2-wide in-order bundle of renamed instructions plus their ROB ids from rename.
- Steers each instruction to the ALU, LSU or BRU reservation station on that station's `dispatch_instruction_0/1`, `rob_id_0/1`, `dispatch_valid_0/1` ports.
- Reservation stations have no backpressure, so this block keeps a free-entry credit counter per station and stalls rename when a bundle cannot be fully placed.

Parameters:
- NUM_RS_ENTRIES, 8: entries per reservation station; initial and maximum credit.
- ROB_WIDTH, 4: ROB id width.
- CW, $clog2(NUM_RS_ENTRIES)+1: credit counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  pipeline flush
- in_instruction_0  in  instruction_t  bundle slot 0 (oldest)
- in_rob_id_0  in  ROB_WIDTH  ROB id, slot 0
- in_valid_0  in  1  slot 0 valid
- in_instruction_1  in  instruction_t  bundle slot 1
- in_rob_id_1  in  ROB_WIDTH  ROB id, slot 1
- in_valid_1  in  1  slot 1 valid; legal only with in_valid_0
- in_ready  out  1  bundle accepted this cycle when high with any valid
- alu_issue_valid, lsu_issue_valid, bru_issue_valid  in  1 each  station issued one entry (credit return)
- {alu,lsu,bru}_dispatch_instruction_0/1  out  instruction_t  per-station dispatch payload
- {alu,lsu,bru}_rob_id_0/1  out  ROB_WIDTH  per-station ROB id
- {alu,lsu,bru}_dispatch_valid_0/1  out  1  per-station dispatch strobe
- alu_credit, lsu_credit, bru_credit  out  CW  current free-entry credits (debug/perf)

Behaviour:
- Reset (async, rst=1):
  - all *_dispatch_valid_* = 0
  - payload and rob_id outputs = 0
  - credits = NUM_RS_ENTRIES
  - in_ready = 1
- Classification by opcode:
  - LOAD, STORE -> LSU
  - BRANCH, JAL, JALR -> BRU
  - all others (OP, OP_IMM, LUI, AUIPC, SYSTEM, ...) -> ALU
- Demand per station = number of valid bundle slots routed to it (0..2).
- in_ready is combinational from registered credits only: high iff demand ≤ credit for all three stations. Same-cycle credit returns are not counted.
- Bundle is all-or-nothing:
  - no partial dispatch; slot 1 never goes out without slot 0.
  - in_valid_1 without in_valid_0 is ignored (treated as an empty bundle).
- Accept = in_ready & in_valid_0 & ~flush.
- Output stage is registered, 1-cycle latency: on accept, the next edge drives each station's port as follows.
  - First instruction routed to a station goes on its _0 port with dispatch_valid_0=1.
  - Second instruction routed to the same station goes on its _1 port with dispatch_valid_1=1.
  - Both slots to one station: slot 0 -> _0, slot 1 -> _1, preserving age order.
  - Unused ports: dispatch_valid = 0; payload holds its previous value.
- Without accept: all dispatch_valid outputs = 0 on the next edge.
- Dispatch valids are single-cycle pulses, never held.
- Credit update per station each edge: credit_next = credit − (accept ? demand : 0) + issue_valid.
  - Simultaneous consume and return is legal (e.g. 1 − 2 is impossible by the in_ready check; 2 − 2 + 1 = 1).
  - A credit exceeding NUM_RS_ENTRIES is an error: assertion; saturate at NUM_RS_ENTRIES.
- Flush (highest priority after reset):
  - next edge: all dispatch_valid = 0
  - credits = NUM_RS_ENTRIES; issue returns that cycle are ignored
  - incoming bundle dropped; in_ready may read high but nothing is accepted
- Rename holds the bundle stable while in_ready=0 and in_valid_0=1.

Optional Feature:
- DISPATCH_STATS_EN defined: adds outputs stall_alu_cnt, stall_lsu_cnt, stall_bru_cnt (32 bits each, saturating).
  - A counter increments each cycle in_valid_0 & ~in_ready & ~flush and that station's demand > credit.
  - Several counters may increment in the same cycle.
  - Counters reset to 0 on rst only; flush does not clear them.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> all dispatch_valid=0, alu/lsu/bru_credit=8, in_ready=1.
- Bundle {OP rob 2, LOAD rob 3} -> next cycle alu_dispatch_valid_0=1 with rob_id 2, lsu_dispatch_valid_0=1 with rob_id 3, all _1 valids 0; alu_credit=7, lsu_credit=7.
- Four {BRANCH, JAL} bundles back-to-back -> bru_credit 8→0, in_ready=0 on the 5th. One bru_issue_valid -> bru_credit=1, 2-BRU bundle still stalled. A further issue -> accepted, bru_credit=0.
- alu_credit=2, bundle {OP, OP_IMM} with alu_issue_valid=1 the same cycle -> accepted, both ALU ports valid next cycle, alu_credit=1.
- Credits {3,5,6}, bundle accepted, flush asserted next cycle -> following cycle all dispatch_valid=0, credits=8. Any bundle presented during flush is not dispatched.
- With DISPATCH_STATS_EN: lsu_credit=1, {LOAD, STORE} held 4 cycles -> stall_lsu_cnt=4, alu and bru counters unchanged.
